// File: rtl/dram_arbiter.sv
// dram_arbiter: round-robin arbiter serialising four core read/write ports onto one RAM port
// Optional read coalescing is built in when DRAM_ARB_COALESCE_EN is defined.
module dram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [3:0]            i_rd,
  input  logic [3:0]            i_wr,
  input  logic [4*ADDR_W-1:0]   i_addr,
  input  logic [4*DATA_W-1:0]   i_wdata,
  output logic [4*DATA_W-1:0]   o_rdata,
  output logic [3:0]            o_ack,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [DATA_W-1:0]     o_mem_wdata,
  output logic                  o_mem_rden,
  output logic                  o_mem_wren,
  input  logic [DATA_W-1:0]     i_mem_q
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t              state_q;
  logic [1:0]          ptr_q, gnt_q, gnt_d;
  logic                wr_q, rden_q, wren_q;
  logic [4:0]          cnt_q;
  logic [3:0]          ack_q, pend, mask;
  logic [ADDR_W-1:0]   mem_addr_q, addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, wdata_d;
  logic [4*DATA_W-1:0] rdata_q;
  assign pend    = i_rd | i_wr;
  assign addr_d  = i_addr[gnt_d*ADDR_W +: ADDR_W];
  assign wdata_d = i_wdata[gnt_d*DATA_W +: DATA_W];
  // First pending core at or above the round-robin pointer, wrapping 3 to 0
  always_comb begin
    gnt_d = ptr_q;
    for (int i = 3; i >= 0; i--)
      if (pend[ptr_q + 2'(i)]) gnt_d = ptr_q + 2'(i);
  end
`ifdef DRAM_ARB_COALESCE_EN
  logic [3:0] mask_q;
  // Other cores reading the granted address while it issues share the same RAM read
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) mask_q <= '0;
    else if (state_q == ISSUE && !wr_q) begin
      for (int k = 0; k < 4; k++)
        mask_q[k] <= 2'(k) != gnt_q && i_rd[k] && !i_wr[k] && i_addr[k*ADDR_W +: ADDR_W] == mem_addr_q;
    end else if (state_q == RESP) mask_q <= '0;
  end
  assign mask = mask_q;
`else
  assign mask = '0;
`endif
  // Arbitration FSM; every output comes straight from a register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      wr_q        <= 1'b0;
      cnt_q       <= '0;
      ack_q       <= '0;
      rden_q      <= 1'b0;
      wren_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      ack_q  <= '0;
      rden_q <= 1'b0;
      wren_q <= 1'b0;
      case (state_q)
        IDLE: if (|pend) begin
          gnt_q      <= gnt_d;
          wr_q       <= i_wr[gnt_d];
          mem_addr_q <= addr_d;
          wren_q     <= i_wr[gnt_d];
          rden_q     <= !i_wr[gnt_d];
          if (i_wr[gnt_d]) mem_wdata_q <= wdata_d;
          state_q    <= ISSUE;
        end
        ISSUE: begin
          cnt_q   <= '0;
          if (wr_q) ack_q <= 4'b0001 << gnt_q;
          state_q <= wr_q ? RESP : WAIT;
        end
        WAIT: if (cnt_q == 5'(RD_LAT - 1)) begin
          for (int k = 0; k < 4; k++)
            if (2'(k) == gnt_q || mask[k]) rdata_q[k*DATA_W +: DATA_W] <= i_mem_q;
          ack_q   <= (4'b0001 << gnt_q) | mask;
          state_q <= RESP;
        end else cnt_q <= cnt_q + 5'd1;
        RESP: begin
          ptr_q   <= gnt_q + 2'd1;
          state_q <= IDLE;
        end
      endcase
    end
  end
  assign o_rdata     = rdata_q;
  assign o_ack       = ack_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_rden  = rden_q;
  assign o_mem_wren  = wren_q;
endmodule
